// File: rtl/lcd_stream_feeder.sv
// Byte stream to LCD transfer converter: buffers UART bytes, tracks the cursor
// and turns printable/control characters into data or command transfers.
module lcd_stream_feeder #(
    parameter int          COLS       = 16,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [7:0]  ROW1_ADDR  = 8'h40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_ready,
    input  logic       init_complete,
    input  logic       lcd_busy,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_valid,
    output logic       overflow,
    output logic       cursor_row,
    output logic [4:0] cursor_col
);

    localparam int             AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    FULL_COUNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [5:0]     COLS_W     = 6'(COLS);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, WRAP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    state_t        state;
    logic          pend_row;
    logic [7:0]    head;
    logic          pop;
    logic          push;
    logic [5:0]    col_inc;

    function automatic logic [7:0] row_addr(input logic row);
        return 8'h80 | (row ? ROW1_ADDR : 8'h00);
    endfunction

    assign head    = mem[rd_ptr];
    assign pop     = (state == FETCH);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push    = rx_ready && ((count != FULL_COUNT) || pop);
    assign col_inc = {1'b0, cursor_col} + 6'd1;

    // NOTE: storage array has no reset; contents are only read behind count,
    // so clearing it would add reset fan-out for no functional gain.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= rx_byte;
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= rx_ready && !push;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lcd_valid  <= 1'b0;
            lcd_data   <= 8'h00;
            lcd_rs     <= 1'b0;
            cursor_row <= 1'b0;
            cursor_col <= 5'd0;
            pend_row   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0 && init_complete)
                        state <= FETCH;
                end
                FETCH: begin
                    if (head >= 8'h20 && head <= 8'h7E) begin
                        lcd_valid <= 1'b1;
                        lcd_rs    <= 1'b1;
                        lcd_data  <= head;
                        state     <= SEND;
                    end else begin
                        // Commands carry their cursor effect in pend_row until completion.
                        case (head)
                            8'h0D: begin
                                lcd_valid <= 1'b1;
                                lcd_rs    <= 1'b0;
                                lcd_data  <= row_addr(cursor_row);
                                pend_row  <= cursor_row;
                                state     <= SEND;
                            end
                            8'h0A: begin
                                lcd_valid <= 1'b1;
                                lcd_rs    <= 1'b0;
                                lcd_data  <= row_addr(~cursor_row);
                                pend_row  <= ~cursor_row;
                                state     <= SEND;
                            end
                            8'h0C: begin
                                lcd_valid <= 1'b1;
                                lcd_rs    <= 1'b0;
                                lcd_data  <= 8'h01;
                                pend_row  <= 1'b0;
                                state     <= SEND;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                SEND: begin
                    if (!lcd_busy) begin
                        if (lcd_rs && col_inc == COLS_W) begin
                            cursor_row <= ~cursor_row;
                            cursor_col <= 5'd0;
                            lcd_rs     <= 1'b0;
                            lcd_data   <= row_addr(~cursor_row);
                            state      <= WRAP;
                        end else if (lcd_rs) begin
                            cursor_col <= col_inc[4:0];
                            lcd_valid  <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            cursor_row <= pend_row;
                            cursor_col <= 5'd0;
                            lcd_valid  <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                WRAP: begin
                    if (!lcd_busy) begin
                        lcd_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_stream_feeder.sv
// Self-checking bench for lcd_stream_feeder: directed scenarios plus random
// byte streams compared against a transfer-list model of the display protocol.
module tb_lcd_stream_feeder;

    localparam int         COLS       = 16;
    localparam int         FIFO_DEPTH = 8;
    localparam logic [7:0] ROW1_ADDR  = 8'h40;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_ready;
    logic       init_complete;
    logic       lcd_busy;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_valid;
    logic       overflow;
    logic       cursor_row;
    logic [4:0] cursor_col;

    always #5 clk = ~clk;

    lcd_stream_feeder #(
        .COLS(COLS), .FIFO_DEPTH(FIFO_DEPTH), .ROW1_ADDR(ROW1_ADDR)
    ) dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_ready(rx_ready),
        .init_complete(init_complete), .lcd_busy(lcd_busy),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_valid(lcd_valid),
        .overflow(overflow), .cursor_row(cursor_row), .cursor_col(cursor_col)
    );

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic       wrap;
    } xfer_t;

    xfer_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    logic  m_row;
    int    m_col;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] addr_of(input logic row);
        return row ? (8'h80 | ROW1_ADDR) : 8'h80;
    endfunction

    task automatic push_exp(input logic rs, input logic [7:0] d, input logic w);
        xfer_t t;
        t.rs = rs; t.data = d; t.wrap = w;
        exp_q.push_back(t);
    endtask

    // Model: what the display should receive for each byte that entered the FIFO.
    task automatic model_accept(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_exp(1'b1, b, 1'b0);
            m_col++;
            if (m_col == COLS) begin
                m_row = !m_row;
                m_col = 0;
                push_exp(1'b0, addr_of(m_row), 1'b1);
            end
        end else if (b == 8'h0D) begin
            push_exp(1'b0, addr_of(m_row), 1'b0);
            m_col = 0;
        end else if (b == 8'h0A) begin
            m_row = !m_row;
            m_col = 0;
            push_exp(1'b0, addr_of(m_row), 1'b0);
        end else if (b == 8'h0C) begin
            push_exp(1'b0, 8'h01, 1'b0);
            m_row = 1'b0;
            m_col = 0;
        end
    endtask

    function automatic logic [7:0] rand_byte();
        int unsigned r;
        logic [7:0]  b;
        r = $urandom_range(0, 39);
        case (r)
            0: b = 8'h0D;
            1: b = 8'h0A;
            2: b = 8'h0C;
            3: begin
                b = 8'($urandom_range(0, 255));
                if ((b >= 8'h20 && b <= 8'h7E) || b == 8'h0A || b == 8'h0C || b == 8'h0D)
                    b = 8'h07;
            end
            default: b = 8'($urandom_range(32, 126));
        endcase
        return b;
    endfunction

    // Inputs change 1 time unit after a rising edge; outputs are read on falling edges.
    task automatic send_byte(input logic [7:0] b, input logic store);
        rx_byte  = b;
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
        if (store)
            model_accept(b);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!lcd_valid && n < budget);
        check("wait_valid", lcd_valid, 1);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || lcd_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check("drain_idle_valid", lcd_valid, 0);
        check("drain_row", cursor_row, m_row);
        check("drain_col", cursor_col, m_col);
        @(posedge clk); #1;
    endtask

    // Handshake monitor: completions in order, stability while stalled, and
    // lcd_valid dropping after completion unless a wrap command follows.
    logic       mon_en = 1'b0;
    logic       prev_hold;
    logic       chk_follow;
    logic       follow_exp;
    logic [7:0] hold_data;
    logic       hold_rs;
    xfer_t      mon_t;

    always @(negedge clk) begin
        if (!mon_en) begin
            prev_hold  = 1'b0;
            chk_follow = 1'b0;
        end else begin
            if (chk_follow)
                check("follow_valid", lcd_valid, follow_exp);
            chk_follow = 1'b0;
            if (prev_hold) begin
                check("hold_valid", lcd_valid, 1);
                check("hold_data", lcd_data, hold_data);
                check("hold_rs", lcd_rs, hold_rs);
            end
            if (lcd_valid && !lcd_busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_xfer", lcd_valid, 0);
                end else begin
                    mon_t = exp_q.pop_front();
                    check("xfer_rs", lcd_rs, mon_t.rs);
                    check("xfer_data", lcd_data, mon_t.data);
                    follow_exp = (exp_q.size() > 0) && exp_q[0].wrap;
                    chk_follow = 1'b1;
                end
            end
            prev_hold = lcd_valid && lcd_busy;
            hold_data = lcd_data;
            hold_rs   = lcd_rs;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] burst [9];
        int         gap;

        rst = 1'b1; rx_byte = 8'h00; rx_ready = 1'b0;
        init_complete = 1'b1; lcd_busy = 1'b0;
        m_row = 1'b0; m_col = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid", lcd_valid, 0);
        check("rst_data", lcd_data, 8'h00);
        check("rst_rs", lcd_rs, 0);
        check("rst_overflow", overflow, 0);
        check("rst_row", cursor_row, 0);
        check("rst_col", cursor_col, 0);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Single 'A': lcd_valid exactly at N+2 for one cycle
        send_byte(8'h41, 1'b1);
        @(negedge clk); check("lat_n0_valid", lcd_valid, 0);
        @(negedge clk); check("lat_n1_valid", lcd_valid, 0);
        @(negedge clk);
        check("lat_n2_valid", lcd_valid, 1);
        check("lat_n2_rs", lcd_rs, 1);
        check("lat_n2_data", lcd_data, 8'h41);
        @(negedge clk);
        check("lat_n3_valid", lcd_valid, 0);
        check("lat_col", cursor_col, 1);
        @(posedge clk); #1;

        // 'B' stalled by lcd_busy
        lcd_busy = 1'b1;
        send_byte(8'h42, 1'b1);
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            check("busy_hold_valid", lcd_valid, 1);
            check("busy_hold_data", lcd_data, 8'h42);
            @(negedge clk);
        end
        @(posedge clk); #1;
        lcd_busy = 1'b0;
        wait_drain(50);

        // CR then 16 printables: wrap from row 0 to row 1 (0xC0)
        send_byte(8'h0D, 1'b1);
        wait_drain(50);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'($urandom_range(32, 126)), 1'b1);
            repeat (4) @(posedge clk);
            #1;
        end
        wait_drain(100);
        check("wrap0_row", cursor_row, 1);
        check("wrap0_col", cursor_col, 0);

        // Control characters
        send_byte(8'h0C, 1'b1); repeat (4) @(posedge clk); #1;
        send_byte(8'h0A, 1'b1); repeat (4) @(posedge clk); #1;
        send_byte(8'h0D, 1'b1); repeat (4) @(posedge clk); #1;
        send_byte(8'h07, 1'b1); repeat (4) @(posedge clk); #1;
        wait_drain(50);
        check("ctrl_row", cursor_row, 1);
        check("ctrl_col", cursor_col, 0);

        // FIFO fill with output held off: 8 stored, 9th dropped
        init_complete = 1'b0;
        lcd_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            burst[i] = 8'($urandom_range(32, 126));
            send_byte(burst[i], i < FIFO_DEPTH);
            @(negedge clk);
            check("fill_overflow", overflow, (i == 8) ? 1 : 0);
            check("fill_no_valid", lcd_valid, 0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("overflow_pulse_end", overflow, 0);
        @(posedge clk); #1;
        init_complete = 1'b1;
        lcd_busy = 1'b0;
        wait_drain(200);
        check("fill_col", cursor_col, 8);

        // Finish row 1: wrap back to row 0 at 0x80
        for (int i = 0; i < 8; i++) begin
            send_byte(8'($urandom_range(32, 126)), 1'b1);
            repeat (4) @(posedge clk);
            #1;
        end
        wait_drain(100);
        check("wrap1_row", cursor_row, 0);
        check("wrap1_col", cursor_col, 0);

        // Random stream with random backpressure
        for (int i = 0; i < 120; i++) begin
            send_byte(rand_byte(), 1'b1);
            gap = $urandom_range(4, 10);
            for (int k = 0; k < gap; k++) begin
                lcd_busy = ($urandom_range(0, 3) == 0);
                @(negedge clk);
                check("rand_no_overflow", overflow, 0);
                @(posedge clk); #1;
            end
        end
        lcd_busy = 1'b0;
        wait_drain(200);

        // Reset in the middle of a stalled transfer with bytes queued
        send_byte(8'h51, 1'b1);
        wait_drain(50);
        lcd_busy = 1'b1;
        send_byte(8'h58, 1'b1);
        send_byte(8'h59, 1'b1);
        send_byte(8'h0A, 1'b1);
        wait_valid(20);
        @(posedge clk); #1;
        mon_en = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        lcd_busy = 1'b0;
        exp_q.delete();
        m_row = 1'b0;
        m_col = 0;
        @(negedge clk);
        check("midrst_valid", lcd_valid, 0);
        check("midrst_row", cursor_row, 0);
        check("midrst_col", cursor_col, 0);
        check("midrst_overflow", overflow, 0);
        mon_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("midrst_quiet", lcd_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
